// File: rtl/fan_btn_conditioner.sv
// Push-button conditioner: per-channel synchronizer, debounce filter and
// press/short/long classifier emitting registered single-cycle pulses.

module fan_btn_chan #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 100_000_000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
  localparam int HW = $clog2(LONG_CYC) + 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX  = '1;

  typedef enum logic [1:0] {RELEASED, PRESSED, LONG_HELD} state_t;

  logic          sync1, sync2, deb;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold;
  state_t        state;
  logic          rise, fall;

  // deb is the filtered level; level is its registered copy, so a
  // deb/level mismatch marks the single cycle an edge was accepted.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb     <= ~deb;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign rise = deb & ~level;
  assign fall = ~deb & level;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state       <= RELEASED;
      level       <= 1'b0;
      hold        <= '0;
      press_pulse <= 1'b0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
    end else begin
      level       <= deb;
      press_pulse <= 1'b0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      case (state)
        RELEASED: if (rise) begin
          state       <= PRESSED;
          press_pulse <= 1'b1;
          hold        <= '0;
        end
        PRESSED: begin
          if (hold != HOLD_MAX) hold <= hold + 1'b1;
          // a release landing on the long edge is reported as short
          if (fall) begin
            state       <= RELEASED;
            short_pulse <= 1'b1;
          end else if (hold == HOLD_LAST) begin
            state      <= LONG_HELD;
            long_pulse <= 1'b1;
          end
        end
        LONG_HELD: if (fall) state <= RELEASED;
        default: state <= RELEASED;
      endcase
    end
  end
endmodule

module fan_btn_conditioner #(
  parameter int N_BTN        = 4,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 100_000_000
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pedge,
  output logic [N_BTN-1:0] btn_short,
  output logic [N_BTN-1:0] btn_long
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    fan_btn_chan #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC)
    ) u_chan (
      .clk        (clk),
      .reset_p    (reset_p),
      .raw        (btn_raw[i]),
      .level      (btn_level[i]),
      .press_pulse(btn_pedge[i]),
      .short_pulse(btn_short[i]),
      .long_pulse (btn_long[i])
    );
  end
endmodule

// File: tb/tb_fan_btn_conditioner.sv
// Directed bench for fan_btn_conditioner with DEBOUNCE_CYC=4, LONG_CYC=20.
// Cycle n is the n-th rising edge after reset is released.

module tb_fan_btn_conditioner;
  logic       clk = 1'b0;
  logic       reset_p;
  logic [3:0] btn_raw;
  logic [3:0] btn_level, btn_pedge, btn_short, btn_long;

  int total = 0;
  int bad   = 0;

  fan_btn_conditioner #(.N_BTN(4), .DEBOUNCE_CYC(4), .LONG_CYC(20)) dut (
    .clk      (clk),
    .reset_p  (reset_p),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pedge(btn_pedge),
    .btn_short(btn_short),
    .btn_long (btn_long)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         ch;
    int         on, off;
    int         npre;
    logic [7:0] pre;
    int         pe, sh, lg, lr, lf;
    int         ncyc;
  } vec_t;

  // per-channel expectations for the current window; 0 means "never"
  int         on_c[4], off_c[4], npre_c[4], pe_c[4], sh_c[4], lg_c[4], lr_c[4], lf_c[4];
  logic [7:0] pre_c[4];

  task automatic check(input string nm, input int n, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %b want %b", nm, n, act, exp);
    end
  endtask

  task automatic clear_exp();
    for (int c = 0; c < 4; c++) begin
      on_c[c] = 0; off_c[c] = 0; npre_c[c] = 0; pre_c[c] = 8'h00;
      pe_c[c] = 0; sh_c[c] = 0; lg_c[c] = 0; lr_c[c] = 0; lf_c[c] = 0;
    end
  endtask

  task automatic do_reset(input string nm);
    reset_p = 1'b1;
    btn_raw = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    check({nm, ".rst_level"}, 0, btn_level, 4'b0);
    check({nm, ".rst_pedge"}, 0, btn_pedge, 4'b0);
    check({nm, ".rst_short"}, 0, btn_short, 4'b0);
    check({nm, ".rst_long"},  0, btn_long,  4'b0);
    reset_p = 1'b0;
  endtask

  task automatic run_window(input string nm, input int ncyc);
    logic [3:0] raw, e_lv, e_pe, e_sh, e_lg;
    do_reset(nm);
    for (int n = 1; n <= ncyc; n++) begin
      for (int c = 0; c < 4; c++) begin
        raw[c] = 1'b0;
        if (n >= on_c[c] && n < off_c[c])
          raw[c] = (n - on_c[c] < npre_c[c]) ? pre_c[c][n - on_c[c]] : 1'b1;
        e_lv[c] = (n >= lr_c[c] && n < lf_c[c]);
        e_pe[c] = (n == pe_c[c]);
        e_sh[c] = (n == sh_c[c]);
        e_lg[c] = (n == lg_c[c]);
      end
      btn_raw = raw;
      @(posedge clk);
      #1;
      check({nm, ".level"}, n, btn_level, e_lv);
      check({nm, ".pedge"}, n, btn_pedge, e_pe);
      check({nm, ".short"}, n, btn_short, e_sh);
      check({nm, ".long"},  n, btn_long,  e_lg);
    end
  endtask

  vec_t vecs[7];

  initial begin
    reset_p = 1'b1;
    btn_raw = 4'b0;

    //            name        ch on  off npre pre           pe  sh  lg  lr  lf  ncyc
    vecs[0] = '{"clean",      0, 10, 16, 0, 8'h00,        16, 22,  0, 16, 22, 30};
    vecs[1] = '{"bounce",     1, 10, 30, 5, 8'b0001_0101, 20, 36,  0, 20, 36, 45};
    vecs[2] = '{"long",       2, 10, 50, 0, 8'h00,        16,  0, 36, 16, 56, 60};
    vecs[3] = '{"glitch3",    3, 10, 13, 0, 8'h00,         0,  0,  0,  0,  0, 25};
    vecs[4] = '{"minpress",   3, 10, 14, 0, 8'h00,        16, 20,  0, 16, 20, 25};
    vecs[5] = '{"collision",  0, 10, 30, 0, 8'h00,        16, 36,  0, 16, 36, 45};
    vecs[6] = '{"just_long",  0, 10, 31, 0, 8'h00,        16,  0, 36, 16, 37, 45};

    foreach (vecs[i]) begin
      clear_exp();
      on_c[vecs[i].ch]   = vecs[i].on;
      off_c[vecs[i].ch]  = vecs[i].off;
      npre_c[vecs[i].ch] = vecs[i].npre;
      pre_c[vecs[i].ch]  = vecs[i].pre;
      pe_c[vecs[i].ch]   = vecs[i].pe;
      sh_c[vecs[i].ch]   = vecs[i].sh;
      lg_c[vecs[i].ch]   = vecs[i].lg;
      lr_c[vecs[i].ch]   = vecs[i].lr;
      lf_c[vecs[i].ch]   = vecs[i].lf;
      run_window(vecs[i].name, vecs[i].ncyc);
    end

    // all four pressed together, button 3 released early
    clear_exp();
    for (int c = 0; c < 4; c++) begin
      on_c[c] = 10; off_c[c] = 45; pe_c[c] = 16;
      lg_c[c] = 36; lr_c[c] = 16; lf_c[c] = 51;
    end
    off_c[3] = 15; lg_c[3] = 0; sh_c[3] = 21; lf_c[3] = 21;
    run_window("simul", 60);

    // reset pulse while button 0 is held in PRESSED
    do_reset("rst_hold");
    for (int n = 1; n <= 60; n++) begin
      logic [3:0] e_lv, e_pe, e_sh;
      reset_p = (n == 25 || n == 26);
      btn_raw = {3'b000, (n >= 10 && n < 45)};
      e_lv = {3'b000, ((n >= 16 && n < 25) || (n >= 33 && n < 51))};
      e_pe = {3'b000, (n == 16 || n == 33)};
      e_sh = {3'b000, (n == 51)};
      @(posedge clk);
      #1;
      check("rst_hold.level", n, btn_level, e_lv);
      check("rst_hold.pedge", n, btn_pedge, e_pe);
      check("rst_hold.short", n, btn_short, e_sh);
      check("rst_hold.long",  n, btn_long,  4'b0);
    end
    reset_p = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
